pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Top-level game sequencer for the Pong design. It owns the game state machine, the remaining-ball count, the two-digit BCD score, and the 2-second inter-ball timer. It drives the text overlay's score and ball inputs and its per-region enables, and it freezes or releases the graphics engine. It sits between the button inputs and hit/miss pulses from the graphics block on one side, and the text/graphics datapath and RGB mux on the other.

## Interface
- TIMER_LOAD, 127: value loaded into the delay timer, in frame ticks (about 2.1 s at 60 Hz); 7 bits.
- BALLS, 3: balls per game; 2 bits, range 1-3.

- clk  in  1  system clock (pixel-clock domain)
- reset  in  1  asynchronous, active-high; clears every register immediately
- btn  in  2  debounced paddle buttons, level-sensitive
- hit  in  1  one-cycle pulse: paddle returned the ball
- miss  in  1  one-cycle pulse: ball passed the paddle
- refr_tick  in  1  one-cycle pulse at start of each frame
- ball  out  2  balls remaining, for display
- dig0  out  4  score units digit, BCD 0-9
- dig1  out  4  score tens digit, BCD 0-9
- gra_still  out  1  1 = graphics frozen (ball parked, paddles idle)
- text_en  out  4  region enables {score, logo, rule, over}
- timer_up  out  1  delay timer at zero

## Operation
- States:
  - NEWGAME: rules screen.
  - PLAY
  - NEWBALL: waiting to serve.
  - OVER: game-over screen.
- NEWGAME:
  - ball ← BALLS and score ← 00, held every cycle.
  - When btn != 0: go to PLAY and load ball ← BALLS-1.
- PLAY:
  - hit increments the score.
  - miss with ball == 0: go to OVER and start the timer.
  - miss with ball != 0: go to NEWBALL, start the timer, and decrement ball.
  - hit and miss in the same cycle: both are honoured, so the score increments and the miss transition occurs.
- NEWBALL:
  - Go to PLAY only when timer_up && btn != 0.
  - A button held through the delay serves as soon as the timer reaches zero.
- OVER:
  - Go to NEWGAME on timer_up.
  - btn is ignored in this state.
- Score is a two-digit BCD counter.
  - An increment at 09 gives 10.
  - An increment at 99 wraps to 00; no saturation and no flag.
  - Clear has priority over increment.
- Timer:
  - Loads TIMER_LOAD on timer start.
  - Otherwise decrements by 1 on each refr_tick while nonzero, and holds at 0.
  - A start and a refr_tick in the same cycle load TIMER_LOAD with no decrement.
- Moore outputs, decoded from the state register:
  - gra_still = 1 in every state except PLAY.
  - text_en[3] (score) = 1 always; text_en[2] (logo) = 1 always.
  - text_en[1] (rule) = 1 in NEWGAME only; text_en[0] (over) = 1 in OVER only.
- hit and miss outside PLAY are ignored.

## Timing
- Reset values:
  - state = NEWGAME, ball = BALLS, dig1:dig0 = 00, timer = 0.
  - gra_still = 1, text_en = 4'b1110, timer_up = 1.
- Reset asserted mid-game: all registers return to their reset values asynchronously. After release the controller waits in NEWGAME for a button.
- Latencies:
  - hit at cycle N → dig1:dig0 updated at N+1.
  - miss at cycle N → state, ball, and timer updated at N+1; timer_up falls at N+1.
  - text_en and gra_still change in the same cycle as the state register, with no extra pipeline stage.
- Timer duration: after loading at N, timer_up rises on the cycle after the TIMER_LOAD-th subsequent refr_tick.
- Button transitions are sampled every cycle with no edge detection. Upstream debouncing is required.

## Structure
- Shared package `pong_pkg`:
  - State enum {NEWGAME, PLAY, NEWBALL, OVER}.
  - text_en bit indices TXT_SCORE=3, TXT_LOGO=2, TXT_RULE=1, TXT_OVER=0.
  - Default TIMER_LOAD and BALLS values.
- One sub-module, `pong_score_counter`: two-digit BCD counter with clr and inc inputs and dig0/dig1 outputs.
- The timer and ball counter stay inline.

## Test plan
- Reset, then btn=2'b01 for one cycle → state PLAY, ball=2, gra_still=0, text_en=4'b1100.
- In PLAY, 12 hit pulses → dig1:dig0 = 1:2. 100 further hits → wraps to 1:2.
- In PLAY, one miss with ball=2 → NEWBALL, ball=1, gra_still=1.
  - btn held with no refr_tick → stays in NEWBALL.
  - After 127 refr_ticks → timer_up=1 and PLAY follows the next cycle.
- Full game of three misses:
  - Third miss (ball=0) → OVER, text_en=4'b1101.
  - After 127 refr_ticks → NEWGAME, score 00, ball=3.
- hit and miss in the same cycle in PLAY at score 05 → score 06 and state NEWBALL.
- Async reset asserted mid-NEWBALL, between clock edges → outputs reach their reset values before the next edge; no button press → state stays NEWGAME.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game controller.
//   state_e       : game sequencer states
//   TXT_*         : bit indices into the text overlay region-enable vector
//   *_DEF         : default timer load value and balls per game
//   bcd_digit_inc : one-digit BCD increment with carry-out
package pong_pkg;

  typedef enum logic [1:0] {
    StNewGame = 2'd0,
    StPlay    = 2'd1,
    StNewBall = 2'd2,
    StOver    = 2'd3
  } state_e;

  localparam int unsigned TXT_SCORE = 3;
  localparam int unsigned TXT_LOGO  = 2;
  localparam int unsigned TXT_RULE  = 1;
  localparam int unsigned TXT_OVER  = 0;

  localparam int unsigned TIMER_LOAD_DEF = 127;
  localparam int unsigned BALLS_DEF      = 3;

  // Returns {carry, next_digit}; 9 rolls over to 0 with carry set.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
    if (d == 4'd9) begin
      return {1'b1, 4'd0};
    end
    return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/pong_score_counter.sv
// Two-digit BCD score counter.
//   i_clk   : clock
//   i_reset : asynchronous active-high reset, score -> 00
//   i_clr   : synchronous clear to 00, wins over i_inc
//   i_inc   : add one; 99 wraps to 00
//   o_dig0  : units digit (BCD)
//   o_dig1  : tens digit (BCD)
module pong_score_counter
  import pong_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_dig0,
  output logic [3:0] o_dig1
);

  logic [3:0] r_dig0;
  logic [3:0] r_dig1;
  logic [3:0] w_dig0_d;
  logic [3:0] w_dig1_d;
  logic [4:0] w_inc0;
  logic [4:0] w_inc1;

  assign w_inc0 = bcd_digit_inc(r_dig0);
  assign w_inc1 = bcd_digit_inc(r_dig1);

  always_comb begin
    w_dig0_d = r_dig0;
    w_dig1_d = r_dig1;
    if (i_clr) begin
      w_dig0_d = 4'd0;
      w_dig1_d = 4'd0;
    end else if (i_inc) begin
      w_dig0_d = w_inc0[3:0];
      // Tens digit only moves on a units carry; its own carry is dropped (wrap).
      if (w_inc0[4]) begin
        w_dig1_d = w_inc1[3:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dig0 <= 4'd0;
      r_dig1 <= 4'd0;
    end else begin
      r_dig0 <= w_dig0_d;
      r_dig1 <= w_dig1_d;
    end
  end

  assign o_dig0 = r_dig0;
  assign o_dig1 = r_dig1;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: state machine, remaining-ball count, BCD score and
// inter-ball delay timer.
//   i_clk       : pixel-domain clock
//   i_reset     : asynchronous active-high reset
//   i_btn       : debounced paddle buttons (level)
//   i_hit       : pulse, paddle returned the ball
//   i_miss      : pulse, ball passed the paddle
//   i_refr_tick : pulse at start of each frame
//   o_ball      : balls remaining
//   o_dig0/1    : score units/tens (BCD)
//   o_gra_still : graphics frozen
//   o_text_en   : text region enables {score, logo, rule, over}
//   o_timer_up  : delay timer at zero
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned TIMER_LOAD = TIMER_LOAD_DEF,
  parameter int unsigned BALLS      = BALLS_DEF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_btn,
  input  logic       i_hit,
  input  logic       i_miss,
  input  logic       i_refr_tick,
  output logic [1:0] o_ball,
  output logic [3:0] o_dig0,
  output logic [3:0] o_dig1,
  output logic       o_gra_still,
  output logic [3:0] o_text_en,
  output logic       o_timer_up
);

  localparam logic [6:0] LP_TIMER_LOAD = 7'(TIMER_LOAD);
  localparam logic [1:0] LP_BALLS      = 2'(BALLS);

  state_e     r_state;
  state_e     w_state_d;
  logic [1:0] r_ball;
  logic [1:0] w_ball_d;
  logic [6:0] r_timer;
  logic [6:0] w_timer_d;
  logic       w_timer_start;
  logic       w_timer_up;
  logic       w_clr;
  logic       w_inc;
  logic       w_btn_any;

  assign w_btn_any  = (i_btn != 2'b00);
  assign w_timer_up = (r_timer == 7'd0);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StNewGame;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_d     = r_state;
    w_ball_d      = r_ball;
    w_timer_start = 1'b0;
    w_clr         = 1'b0;
    w_inc         = 1'b0;
    unique case (r_state)
      StNewGame: begin
        w_clr    = 1'b1;
        w_ball_d = LP_BALLS;
        if (w_btn_any) begin
          w_state_d = StPlay;
          w_ball_d  = LP_BALLS - 2'd1;
        end
      end
      StPlay: begin
        // hit and miss are independent so a simultaneous pair does both.
        w_inc = i_hit;
        if (i_miss) begin
          w_timer_start = 1'b1;
          if (r_ball == 2'd0) begin
            w_state_d = StOver;
          end else begin
            w_state_d = StNewBall;
            w_ball_d  = r_ball - 2'd1;
          end
        end
      end
      StNewBall: begin
        if (w_timer_up && w_btn_any) begin
          w_state_d = StPlay;
        end
      end
      StOver: begin
        if (w_timer_up) begin
          w_state_d = StNewGame;
        end
      end
      default: w_state_d = StNewGame;
    endcase
  end

  // Moore outputs
  always_comb begin
    o_text_en            = 4'b0000;
    o_text_en[TXT_SCORE] = 1'b1;
    o_text_en[TXT_LOGO]  = 1'b1;
    o_text_en[TXT_RULE]  = (r_state == StNewGame);
    o_text_en[TXT_OVER]  = (r_state == StOver);
    o_gra_still          = (r_state != StPlay);
  end

  // Delay timer: a start overrides a coincident frame tick.
  always_comb begin
    w_timer_d = r_timer;
    if (w_timer_start) begin
      w_timer_d = LP_TIMER_LOAD;
    end else if (i_refr_tick && !w_timer_up) begin
      w_timer_d = r_timer - 7'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ball  <= LP_BALLS;
      r_timer <= 7'd0;
    end else begin
      r_ball  <= w_ball_d;
      r_timer <= w_timer_d;
    end
  end

  pong_score_counter u_score (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_dig0  (o_dig0),
    .o_dig1  (o_dig1)
  );

  assign o_ball     = r_ball;
  assign o_timer_up = w_timer_up;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a vector table for the early game plus
// hand-written sequences for the timer, score wrap, game over and async reset.
module tb_pong_game_ctrl;

  logic       i_clk;
  logic       i_reset;
  logic [1:0] i_btn;
  logic       i_hit;
  logic       i_miss;
  logic       i_refr_tick;
  logic [1:0] o_ball;
  logic [3:0] o_dig0;
  logic [3:0] o_dig1;
  logic       o_gra_still;
  logic [3:0] o_text_en;
  logic       o_timer_up;

  int n_vec = 0;
  int n_err = 0;

  pong_game_ctrl dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_btn       (i_btn),
    .i_hit       (i_hit),
    .i_miss      (i_miss),
    .i_refr_tick (i_refr_tick),
    .o_ball      (o_ball),
    .o_dig0      (o_dig0),
    .o_dig1      (o_dig1),
    .o_gra_still (o_gra_still),
    .o_text_en   (o_text_en),
    .o_timer_up  (o_timer_up)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Expected-output record: {ball, dig1, dig0, gra_still, text_en, timer_up}
  function automatic logic [15:0] pk(input logic [1:0] b, input logic [3:0] d1,
                                     input logic [3:0] d0, input logic s,
                                     input logic [3:0] t, input logic u);
    return {b, d1, d0, s, t, u};
  endfunction

  // Screen encodings per state
  localparam logic [3:0] TxNg = 4'b1110;
  localparam logic [3:0] TxPl = 4'b1100;
  localparam logic [3:0] TxOv = 4'b1101;

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {o_ball, o_dig1, o_dig0, o_gra_still, o_text_en, o_timer_up};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ball=%0d score=%h%h still=%b text=%b tup=%b, want ball=%0d score=%h%h still=%b text=%b tup=%b",
               name, act[15:14], act[13:10], act[9:6], act[5], act[4:1], act[0],
               exp[15:14], exp[13:10], exp[9:6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  // Apply inputs for one clock; returns 1 ns after the active edge.
  task automatic cyc(input logic [1:0] b, input logic h, input logic m, input logic t);
    i_btn       = b;
    i_hit       = h;
    i_miss      = m;
    i_refr_tick = t;
    @(posedge i_clk);
    #1;
    i_btn       = 2'b00;
    i_hit       = 1'b0;
    i_miss      = 1'b0;
    i_refr_tick = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  btn;
    logic        hit;
    logic        miss;
    logic        tick;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{"ng_idle",     2'b00, 1'b0, 1'b0, 1'b0, pk(2'd3, 4'd0, 4'd0, 1'b1, TxNg, 1'b1)};
    tbl[1]  = '{"ng_hit_ign",  2'b00, 1'b1, 1'b0, 1'b0, pk(2'd3, 4'd0, 4'd0, 1'b1, TxNg, 1'b1)};
    tbl[2]  = '{"ng_miss_ign", 2'b00, 1'b0, 1'b1, 1'b0, pk(2'd3, 4'd0, 4'd0, 1'b1, TxNg, 1'b1)};
    tbl[3]  = '{"ng_start",    2'b01, 1'b0, 1'b0, 1'b0, pk(2'd2, 4'd0, 4'd0, 1'b0, TxPl, 1'b1)};
    tbl[4]  = '{"pl_hit1",     2'b00, 1'b1, 1'b0, 1'b0, pk(2'd2, 4'd0, 4'd1, 1'b0, TxPl, 1'b1)};
    tbl[5]  = '{"pl_hit2",     2'b00, 1'b1, 1'b0, 1'b0, pk(2'd2, 4'd0, 4'd2, 1'b0, TxPl, 1'b1)};
    tbl[6]  = '{"pl_btn",      2'b11, 1'b0, 1'b0, 1'b0, pk(2'd2, 4'd0, 4'd2, 1'b0, TxPl, 1'b1)};
    tbl[7]  = '{"pl_hit_miss", 2'b00, 1'b1, 1'b1, 1'b0, pk(2'd1, 4'd0, 4'd3, 1'b1, TxPl, 1'b0)};
    tbl[8]  = '{"nb_hit_ign",  2'b00, 1'b1, 1'b0, 1'b0, pk(2'd1, 4'd0, 4'd3, 1'b1, TxPl, 1'b0)};
    tbl[9]  = '{"nb_tick",     2'b00, 1'b0, 1'b0, 1'b1, pk(2'd1, 4'd0, 4'd3, 1'b1, TxPl, 1'b0)};
    tbl[10] = '{"nb_btn_wait", 2'b10, 1'b0, 1'b0, 1'b0, pk(2'd1, 4'd0, 4'd3, 1'b1, TxPl, 1'b0)};

    i_reset     = 1'b1;
    i_btn       = 2'b00;
    i_hit       = 1'b0;
    i_miss      = 1'b0;
    i_refr_tick = 1'b0;
    #3;
    check("reset", pk(2'd3, 4'd0, 4'd0, 1'b1, TxNg, 1'b1));
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].btn, tbl[i].hit, tbl[i].miss, tbl[i].tick);
      check(tbl[i].name, tbl[i].exp);
    end

    // NEWBALL: timer at 126; button alone does not serve.
    for (int i = 0; i < 5; i++) cyc(2'b01, 1'b0, 1'b0, 1'b0);
    check("nb_hold_no_tick", pk(2'd1, 4'd0, 4'd3, 1'b1, TxPl, 1'b0));
    for (int i = 0; i < 125; i++) cyc(2'b01, 1'b0, 1'b0, 1'b1);
    check("nb_timer_1", pk(2'd1, 4'd0, 4'd3, 1'b1, TxPl, 1'b0));
    cyc(2'b01, 1'b0, 1'b0, 1'b1);
    check("nb_timer_up", pk(2'd1, 4'd0, 4'd3, 1'b1, TxPl, 1'b1));
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    check("nb_serve", pk(2'd1, 4'd0, 4'd3, 1'b0, TxPl, 1'b1));

    // Score carries and wrap
    for (int i = 0; i < 6; i++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
    check("score_09", pk(2'd1, 4'd0, 4'd9, 1'b0, TxPl, 1'b1));
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    check("score_10", pk(2'd1, 4'd1, 4'd0, 1'b0, TxPl, 1'b1));
    for (int i = 0; i < 89; i++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
    check("score_99", pk(2'd1, 4'd9, 4'd9, 1'b0, TxPl, 1'b1));
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    check("score_wrap", pk(2'd1, 4'd0, 4'd0, 1'b0, TxPl, 1'b1));
    for (int i = 0; i < 12; i++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
    check("score_12", pk(2'd1, 4'd1, 4'd2, 1'b0, TxPl, 1'b1));
    for (int i = 0; i < 100; i++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
    check("score_112", pk(2'd1, 4'd1, 4'd2, 1'b0, TxPl, 1'b1));

    // Last ball, then game over
    cyc(2'b00, 1'b0, 1'b1, 1'b0);
    check("miss_ball1", pk(2'd0, 4'd1, 4'd2, 1'b1, TxPl, 1'b0));
    for (int i = 0; i < 127; i++) cyc(2'b00, 1'b0, 1'b0, 1'b1);
    check("nb2_timer_up", pk(2'd0, 4'd1, 4'd2, 1'b1, TxPl, 1'b1));
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    check("nb2_serve", pk(2'd0, 4'd1, 4'd2, 1'b0, TxPl, 1'b1));
    cyc(2'b00, 1'b0, 1'b1, 1'b0);
    check("over_enter", pk(2'd0, 4'd1, 4'd2, 1'b1, TxOv, 1'b0));
    cyc(2'b11, 1'b1, 1'b0, 1'b0);
    check("over_btn_ign", pk(2'd0, 4'd1, 4'd2, 1'b1, TxOv, 1'b0));
    for (int i = 0; i < 126; i++) cyc(2'b00, 1'b0, 1'b0, 1'b1);
    check("over_timer_1", pk(2'd0, 4'd1, 4'd2, 1'b1, TxOv, 1'b0));
    cyc(2'b00, 1'b0, 1'b0, 1'b1);
    check("over_timer_up", pk(2'd0, 4'd1, 4'd2, 1'b1, TxOv, 1'b1));
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    check("newgame_again", pk(2'd3, 4'd0, 4'd0, 1'b1, TxNg, 1'b1));

    // Simultaneous hit and miss at 05
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    check("g2_start", pk(2'd2, 4'd0, 4'd0, 1'b0, TxPl, 1'b1));
    for (int i = 0; i < 5; i++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
    check("g2_score_05", pk(2'd2, 4'd0, 4'd5, 1'b0, TxPl, 1'b1));
    cyc(2'b00, 1'b1, 1'b1, 1'b0);
    check("g2_hit_miss", pk(2'd1, 4'd0, 4'd6, 1'b1, TxPl, 1'b0));

    // Async reset between edges while in NEWBALL
    #2;
    i_reset = 1'b1;
    #1;
    check("async_reset", pk(2'd3, 4'd0, 4'd0, 1'b1, TxNg, 1'b1));
    #1;
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, 1'b1, 1'b1);
    check("post_reset_wait", pk(2'd3, 4'd0, 4'd0, 1'b1, TxNg, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
